// File: rtl/bus_pkg.sv
// Shared definitions for the PET system-bus slot arbiter.
// Slot phase offsets are relative to the slot start or end.
package bus_pkg;

  localparam int STRB_START   = 2;
  localparam int STRB_END_OFS = 2;
  localparam int CAP_OFS      = 2;
  localparam int RDY_OFS      = 1;

  localparam logic [3:0] VRAM_BASE = 4'h8;

  typedef enum logic {
    VRAM_40COL = 1'b0,
    VRAM_80COL = 1'b1
  } vram_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_REQ
  } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, with wrap.
// Purely combinational.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     idx,
  output logic              found
);

  int c;

  // Walk downward so the lowest offset from ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[c[IW-1:0]]) begin
        idx   = c[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Time-slot arbiter for the shared PET bus: slot 0 is the 6502,
// the other slots go round-robin to handshaked requesters.
module bus_slot_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int FRAME_SLOTS = 2,
  parameter int SLOT_CYCLES = 8,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8
) (
  input  logic                          clk_sys_i,
  input  logic                          reset_i,
  input  logic [NUM_CH-1:0]             req_valid_i,
  input  logic [NUM_CH-1:0]             req_rw_ni,
  input  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]             req_ready_o,
  output logic [DATA_W-1:0]             rd_data_o,
  input  logic [DATA_W-1:0]             bus_data_i,
  output logic [ADDR_W-1:0]             bus_addr_o,
  output logic [DATA_W-1:0]             bus_data_o,
  output logic                          bus_addr_oe_o,
  output logic                          bus_data_oe_o,
  output logic                          bus_rw_no,
  input  logic [ADDR_W-1:0]             cpu_addr_i,
  input  logic                          cpu_rw_ni,
  input  logic                          cpu_ready_i,
  input  logic                          cpu_wp_i,
  input  logic                          vram_mode_i,
  output logic                          clk_cpu_o,
  output logic                          cpu_en_o,
  output logic [1:0]                    ram_addr_o,
  output logic                          ram_oe_no,
  output logic                          ram_we_no,
  output logic [3:0]                    grant_o
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int SW = $clog2(FRAME_SLOTS);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]     cyc, cyc_nx;
  logic [SW-1:0]     slot, slot_nx;
  logic [IW-1:0]     rr, owner, arb_idx;
  logic [NUM_CH-1:0] arb_req;
  logic              arb_found, cyc_last, in_win;
  slot_state_t       st, st_nx;
  vram_mode_t        vmode;
  logic              unused_ok;

  assign vmode     = vram_mode_t'(vram_mode_i);
  assign cpu_en_o  = clk_cpu_o & cpu_ready_i;
  assign unused_ok = ^cpu_addr_i;

  // The channel acked this cycle must not be re-granted on the same edge.
  assign arb_req = req_valid_i & ~req_ready_o;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (arb_req),
    .ptr   (rr),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    cyc_last = int'(cyc) == SLOT_CYCLES - 1;
    cyc_nx   = cyc_last ? '0 : cyc + 1'b1;
    slot_nx  = (int'(slot) == FRAME_SLOTS - 1) ? '0 : slot + 1'b1;
    in_win   = int'(cyc_nx) >= STRB_START &&
               int'(cyc_nx) <= SLOT_CYCLES - STRB_END_OFS;
    if (slot_nx == '0)  st_nx = ST_CPU;
    else if (arb_found) st_nx = ST_REQ;
    else                st_nx = ST_IDLE;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      cyc           <= '0;
      slot          <= '0;
      rr            <= '0;
      owner         <= '0;
      st            <= ST_IDLE;
      grant_o       <= '0;
      clk_cpu_o     <= 1'b0;
      ram_oe_no     <= 1'b1;
      ram_we_no     <= 1'b1;
      bus_addr_oe_o <= 1'b0;
      bus_data_oe_o <= 1'b0;
      bus_rw_no     <= 1'b1;
      bus_addr_o    <= '0;
      bus_data_o    <= '0;
      req_ready_o   <= '0;
      rd_data_o     <= '0;
    end else begin
      cyc         <= cyc_nx;
      req_ready_o <= '0;
      ram_oe_no   <= 1'b1;
      ram_we_no   <= 1'b1;
      if (cyc_last) begin
        slot          <= slot_nx;
        st            <= st_nx;
        clk_cpu_o     <= st_nx == ST_CPU;
        bus_addr_oe_o <= st_nx == ST_REQ;
        bus_data_oe_o <= 1'b0;
        bus_rw_no     <= 1'b1;
        grant_o       <= '0;
        if (st_nx == ST_REQ) begin
          owner         <= arb_idx;
          rr            <= (int'(arb_idx) == NUM_CH - 1) ?
                           '0 : arb_idx + 1'b1;
          grant_o       <= 4'(arb_idx) + 4'd1;
          bus_addr_o    <= req_addr_i[arb_idx];
          bus_data_o    <= req_data_i[arb_idx];
          bus_rw_no     <= req_rw_ni[arb_idx];
          bus_data_oe_o <= !req_rw_ni[arb_idx];
        end
      end
      if (st == ST_CPU && cpu_ready_i) begin
        ram_oe_no <= !(in_win && cpu_rw_ni);
        ram_we_no <= !(in_win && !cpu_rw_ni && !cpu_wp_i);
      end else if (st == ST_REQ) begin
        ram_oe_no <= !(in_win && bus_rw_no);
        ram_we_no <= !(in_win && !bus_rw_no);
      end
      if (st == ST_REQ) begin
        if (int'(cyc) == SLOT_CYCLES - CAP_OFS && bus_rw_no)
          rd_data_o <= bus_data_i;
        if (int'(cyc_nx) == SLOT_CYCLES - RDY_OFS)
          req_ready_o[owner] <= 1'b1;
      end
    end
  end

  // Video RAM mirroring only applies to 6502 accesses.
  always_comb begin
    ram_addr_o = bus_addr_o[11:10];
    if (st != ST_REQ) begin
      ram_addr_o = cpu_addr_i[11:10];
      if (cpu_addr_i[15:12] == VRAM_BASE)
        ram_addr_o = (vmode == VRAM_80COL) ?
                     {1'b0, cpu_addr_i[10]} : 2'b00;
    end
  end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Directed bench for bus_slot_arbiter: vector table for the first
// frames plus hand sequences for mirroring, halt, reset and fairness.
module tb_bus_slot_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i;
  logic [1:0]       req_valid, req_rw_n, req_ready;
  logic [1:0][16:0] req_addr;
  logic [1:0][7:0]  req_data;
  logic [7:0]       rd_data, bus_din, bus_dout, ram_model;
  logic [16:0]      bus_addr, cpu_addr;
  logic             aoe, doe, rw_n, cpu_rw_n, cpu_ready, cpu_wp, vmode;
  logic             clk_cpu, cpu_en, oe_n, we_n;
  logic [1:0]       ram_addr;
  logic [3:0]       grant;

  logic [2:0]       r3_valid, r3_rw_n, r3_ready;
  logic [2:0][16:0] r3_addr;
  logic [2:0][7:0]  r3_data;
  logic [7:0]       r3_rd, r3_dout, zero8;
  logic [16:0]      r3_baddr;
  logic             r3_aoe, r3_doe, r3_rw, r3_clk, r3_en, r3_oe, r3_we;
  logic [1:0]       r3_ram;
  logic [3:0]       r3_grant;

  assign bus_din = oe_n ? 8'h00 : ram_model;

  bus_slot_arbiter u_dut (
    .clk_sys_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_rw_ni(req_rw_n),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .rd_data_o(rd_data),
    .bus_data_i(bus_din), .bus_addr_o(bus_addr),
    .bus_data_o(bus_dout), .bus_addr_oe_o(aoe),
    .bus_data_oe_o(doe), .bus_rw_no(rw_n),
    .cpu_addr_i(cpu_addr), .cpu_rw_ni(cpu_rw_n),
    .cpu_ready_i(cpu_ready), .cpu_wp_i(cpu_wp),
    .vram_mode_i(vmode), .clk_cpu_o(clk_cpu), .cpu_en_o(cpu_en),
    .ram_addr_o(ram_addr), .ram_oe_no(oe_n), .ram_we_no(we_n),
    .grant_o(grant)
  );

  bus_slot_arbiter #(.NUM_CH(3), .FRAME_SLOTS(4)) u_dut3 (
    .clk_sys_i(clk), .reset_i(reset_i),
    .req_valid_i(r3_valid), .req_rw_ni(r3_rw_n),
    .req_addr_i(r3_addr), .req_data_i(r3_data),
    .req_ready_o(r3_ready), .rd_data_o(r3_rd),
    .bus_data_i(zero8), .bus_addr_o(r3_baddr),
    .bus_data_o(r3_dout), .bus_addr_oe_o(r3_aoe),
    .bus_data_oe_o(r3_doe), .bus_rw_no(r3_rw),
    .cpu_addr_i(cpu_addr), .cpu_rw_ni(cpu_rw_n),
    .cpu_ready_i(cpu_ready), .cpu_wp_i(cpu_wp),
    .vram_mode_i(vmode), .clk_cpu_o(r3_clk), .cpu_en_o(r3_en),
    .ram_addr_o(r3_ram), .ram_oe_no(r3_oe), .ram_we_no(r3_we),
    .grant_o(r3_grant)
  );

  typedef struct {
    int         k;
    logic [3:0] grant;
    logic       oe;
    logic [1:0] rdy;
    logic       clkc;
    logic       aoe;
    logic [7:0] rd;
  } vec_t;

  localparam logic [24:0] RST_V =
    {2'b00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  vec_t tbl[12];
  int   k, checks, errors;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic goto(input int m);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((k % 16) != m && n < 32);
  endtask

  function automatic logic [24:0] outs();
    return {req_ready, rd_data, grant, clk_cpu, cpu_en,
            oe_n, we_n, aoe, doe, rw_n};
  endfunction

  initial begin
    int bad, rc, rk;
    int cnt3[3];
    checks = 0;
    errors = 0;
    k = 0;
    tbl[0]  = '{1,  4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{7,  4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{8,  4'd1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{9,  4'd1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{10, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{14, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{15, 4'd1, 1'b1, 2'b01, 1'b0, 1'b1, 8'hA5};
    tbl[7]  = '{16, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 8'hA5};
    tbl[8]  = '{18, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5};
    tbl[9]  = '{23, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 8'hA5};
    tbl[10] = '{24, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 8'hA5};
    tbl[11] = '{28, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 8'hA5};

    reset_i   = 1'b1;
    req_valid = 2'b01;
    req_rw_n  = 2'b11;
    req_addr  = '0;
    req_addr[0] = 17'h0_1234;
    req_data  = '0;
    cpu_addr  = '0;
    cpu_rw_n  = 1'b1;
    cpu_ready = 1'b1;
    cpu_wp    = 1'b0;
    vmode     = 1'b0;
    ram_model = 8'hA5;
    zero8     = 8'h00;
    r3_valid  = 3'b111;
    r3_rw_n   = 3'b111;
    r3_addr   = '0;
    r3_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs()), 32'(RST_V));
    reset_i = 1'b0;
    k = 0;

    for (int i = 0; i < 12; i++) begin
      while (k < tbl[i].k) begin
        if (k == 15) req_valid = 2'b00;
        step();
      end
      chk($sformatf("vec%0d_grant", tbl[i].k), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d_oe", tbl[i].k), 32'(oe_n), 32'(tbl[i].oe));
      chk($sformatf("vec%0d_ready", tbl[i].k), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_clkcpu", tbl[i].k), 32'(clk_cpu), 32'(tbl[i].clkc));
      chk($sformatf("vec%0d_addroe", tbl[i].k), 32'(aoe), 32'(tbl[i].aoe));
      chk($sformatf("vec%0d_rddata", tbl[i].k), 32'(rd_data), 32'(tbl[i].rd));
      if (tbl[i].k == 8)
        chk("vec8_busaddr", 32'(bus_addr), 32'h0_1234);
    end

    // CPU write into the video window, both modes, then write-protect
    cpu_addr = 17'h0_8C05;
    cpu_rw_n = 1'b0;
    goto(3);
    chk("cpu_we_mode0", 32'(we_n), 32'd0);
    chk("cpu_mirror_mode0", 32'(ram_addr), 32'd0);
    chk("cpu_en_slot", 32'(cpu_en), 32'd1);
    vmode = 1'b1;
    goto(3);
    chk("cpu_mirror_mode1", 32'(ram_addr), 32'd1);
    cpu_wp = 1'b1;
    goto(3);
    chk("cpu_wp_we", 32'(we_n), 32'd1);

    req_valid   = 2'b10;
    req_rw_n    = 2'b01;
    req_addr[1] = 17'h0_8C05;
    req_data[1] = 8'h3C;
    goto(11);
    chk("rq_wr_grant", 32'(grant), 32'd2);
    chk("rq_wr_doe", 32'(doe), 32'd1);
    chk("rq_wr_rw", 32'(rw_n), 32'd0);
    chk("rq_wr_nomirror", 32'(ram_addr), 32'd3);
    chk("rq_wr_we", 32'(we_n), 32'd0);
    chk("rq_wr_data", 32'(bus_dout), 32'h3C);
    goto(15);
    chk("rq_wr_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b00;

    // Halted CPU: clock still runs, no enable and no strobes
    cpu_ready   = 1'b0;
    cpu_rw_n    = 1'b1;
    cpu_wp      = 1'b0;
    cpu_addr    = '0;
    vmode       = 1'b0;
    ram_model   = 8'h6E;
    req_rw_n    = 2'b11;
    req_addr[0] = 17'h0_0042;
    req_valid   = 2'b01;
    goto(0);
    chk("halt_clk_hi", 32'(clk_cpu), 32'd1);
    chk("halt_en", 32'(cpu_en), 32'd0);
    goto(4);
    chk("halt_oe", 32'(oe_n), 32'd1);
    chk("halt_we", 32'(we_n), 32'd1);
    goto(8);
    chk("halt_clk_lo", 32'(clk_cpu), 32'd0);
    chk("halt_grant", 32'(grant), 32'd1);
    goto(15);
    chk("halt_ready", 32'(req_ready), 32'd1);
    chk("halt_rddata", 32'(rd_data), 32'h6E);
    req_valid = 2'b00;
    cpu_ready = 1'b1;

    // Ten frames without requests
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if ((k % 16) >= 8 &&
          (aoe || !oe_n || !we_n || grant != 4'd0)) bad++;
    end
    chk("idle_frames", 32'(bad), 32'd0);

    // Reset in the middle of a requester write
    req_rw_n    = 2'b10;
    req_addr[0] = 17'h0_0100;
    req_data[0] = 8'h77;
    req_valid   = 2'b01;
    goto(12);
    chk("pre_rst_grant", 32'(grant), 32'd1);
    chk("pre_rst_we", 32'(we_n), 32'd0);
    reset_i = 1'b1;
    step();
    chk("midslot_reset", 32'(outs()), 32'(RST_V));
    step();
    step();
    reset_i = 1'b0;
    k  = 0;
    rc = 0;
    rk = -1;
    for (int j = 0; j < 3; j++) cnt3[j] = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (req_ready[0]) begin
        rc++;
        rk = k;
        req_valid = 2'b00;
      end
      for (int j = 0; j < 3; j++)
        if (r3_ready[j]) cnt3[j]++;
      if (k == 11) chk("rewrite_we", 32'(we_n), 32'd0);
      if ((k % 8) == 1)
        chk($sformatf("rr3_grant_k%0d", k), 32'(r3_grant),
            32'((k / 8) % 4));
      if (k == 33) chk("rr3_cpu_slot", 32'(r3_clk), 32'd1);
    end
    chk("rewrite_ready_count", 32'(rc), 32'd1);
    chk("rewrite_ready_cycle", 32'(rk), 32'd15);
    for (int j = 0; j < 3; j++)
      chk($sformatf("rr3_served_ch%0d", j), 32'(cnt3[j]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_slot_arbiter.md
# bus_slot_arbiter

Parametrised time-slot arbiter for the shared PET system bus. Generalises the fixed CPU/RPi split into a frame of `FRAME_SLOTS` bus slots. Slot 0 always belongs to the 6502. The remaining slots are granted round-robin to `NUM_CH` handshaked requesters (SPI bridge, video fetch, DMA). The block generates RAM strobes, the CPU clock, and VRAM-mirrored RAM address bits; it sits between the requesters and the top-level bus drivers.

## Interface
- `NUM_CH`, 2, number of handshaked requesters (excludes CPU); 1..8
- `FRAME_SLOTS`, 2, slots per CPU cycle; 2..16
- `SLOT_CYCLES`, 8, `clk_sys_i` cycles per slot; minimum 6
- `ADDR_W`, 17, bus address width
- `DATA_W`, 8, bus data width
- `clk_sys_i` in 1 system clock (16 MHz)
- `reset_i` in 1 synchronous, active-high reset; the block has one clock domain only
- `req_valid_i` in NUM_CH: per-channel request pending
- `req_rw_ni` in NUM_CH: 1 = read, 0 = write
- `req_addr_i` in NUM_CH×ADDR_W: request address
- `req_data_i` in NUM_CH×DATA_W: write data
- `req_ready_o` out NUM_CH: one-cycle completion pulse
- `rd_data_o` out DATA_W: read data; valid with the ready pulse and held until the next read completes
- `bus_data_i` in DATA_W: sampled bus data
- `bus_addr_o` out ADDR_W: requester address
- `bus_data_o` out DATA_W: requester write data
- `bus_addr_oe_o` out 1: requester drives addr/rw
- `bus_data_oe_o` out 1: requester drives data
- `bus_rw_no` out 1: requester rw
- `cpu_addr_i` in ADDR_W: CPU address
- `cpu_rw_ni` in 1: CPU rw
- `cpu_ready_i` in 1: 0 = CPU halted
- `cpu_wp_i` in 1: decoded write-protect for the current CPU address
- `vram_mode_i` in 1: 0 = 40-column (1 KB ×4), 1 = 80-column (2 KB ×2)
- `clk_cpu_o` out 1: CPU clock
- `cpu_en_o` out 1: CPU bus enable
- `ram_addr_o` out 2: RAM A11..A10
- `ram_oe_no` out 1: RAM output enable, active-low
- `ram_we_no` out 1: RAM write enable, active-low
- `grant_o` out 4: current slot owner; 0 = CPU/idle, c+1 = requester c

## Operation
- Counters: `cyc` runs 0..SLOT_CYCLES-1. `slot` runs 0..FRAME_SLOTS-1 and increments when `cyc` wraps; `slot` wraps to 0.
- Owner is decided at the edge entering `cyc`=0.
  - Slot 0 belongs to the CPU.
  - Any other slot goes to the first requester with `req_valid_i` set, searching from the round-robin pointer `rr` upward with wrap. `rr` then becomes owner+1 mod NUM_CH.
  - If no request is valid, the slot is idle: no strobes, no OE.
- CPU slot:
  - `clk_cpu_o` is high for the whole slot and low otherwise.
  - `cpu_en_o` = `cpu_ready_i` for the whole slot.
  - RAM strobes follow `cpu_rw_ni`.
  - Write is suppressed when `cpu_wp_i` is set.
  - Strobes are suppressed when `cpu_ready_i` is 0.
- Requester slot: address, data and rw are registered from the owner at `cyc`=0 and held for the slot. `bus_addr_oe_o` is 1 for the slot. `bus_data_oe_o` is 1 for writes only.
- Mirroring applies to CPU slots only, when `cpu_addr_i`[15:12]=4'h8:
  - mode 0: `ram_addr_o`=2'b00
  - mode 1: `ram_addr_o`={1'b0, `cpu_addr_i`[10]}
- Otherwise `ram_addr_o` passes the current address [11:10] unmodified. Requesters always get unmirrored addresses.

## Timing
- Strobe `ram_oe_no`/`ram_we_no` is asserted low for `cyc` 2..SLOT_CYCLES-2 and is registered, so it is glitch-free.
- Read data is captured from `bus_data_i` at the edge ending `cyc`=SLOT_CYCLES-2.
- `req_ready_o`[owner] pulses at `cyc`=SLOT_CYCLES-1 for both reads and writes.
- A requester must hold valid, addr, rw and data until its ready pulse. It may drop valid the cycle after ready or issue a new request immediately. A new request is served no earlier than the next requester slot.
- Latency from valid to ready is at most (NUM_CH×FRAME_SLOTS/(FRAME_SLOTS-1)+2)×SLOT_CYCLES cycles.
- Valid rising during a slot is ignored until the next slot decision.
- Reset values:
  - `cyc`=0, `slot`=0, `rr`=0, `grant_o`=0
  - `clk_cpu_o`=0, `cpu_en_o`=0
  - `ram_oe_no`=1, `ram_we_no`=1
  - `bus_addr_oe_o`=0, `bus_data_oe_o`=0, `bus_rw_no`=1
  - `req_ready_o`=0, `rd_data_o`=0
- Reset mid-slot aborts the slot with no ready pulse. The pending requester is re-served later.
- Outputs are valid from the first cycle after release.

## Structure
- `bus_pkg` holds the slot-phase localparams (strobe start, strobe end, capture, ready), the `vram_mode_t` enum, and `VRAM_BASE`=4'h8.
- Sub-module `rr_arbiter`: NUM_CH-wide request vector plus pointer in, owner index and found flag out. Purely combinational.
- Top level contains the counters, slot FSM (IDLE/CPU/REQ), and output registers.

## Test plan
- Defaults, single requester holding a read at 17'h0_1234 with RAM model data 8'hA5: served in slot 1; `ram_oe_no` low for cycles 2..6; ready at cycle 7 with `rd_data_o`=8'hA5; `clk_cpu_o` duty 50 %.
- NUM_CH=3, FRAME_SLOTS=4, all three requesters continuously valid: grant order 1,2,3,1,2,3 across slots 1..3; none starved; CPU slot every 4th slot.
- CPU write to 16'h8C05: mode 0 gives `ram_addr_o`=00; mode 1 gives `ram_addr_o`=01. CPU write with `cpu_wp_i`=1 keeps `ram_we_no` high. Requester write to 16'h8C05 gives `ram_addr_o`=11.
- `cpu_ready_i`=0: `clk_cpu_o` still toggles; `cpu_en_o` stays 0; no strobes in slot 0; requester traffic unaffected.
- Assert `reset_i` at `cyc`=4 of a requester write: no ready pulse; all outputs at reset values. After release the write completes once, with exactly one ready pulse.
- No requests for 10 frames: requester slots idle, `bus_addr_oe_o`=0, strobes high, `grant_o`=0.
